// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if
//   Groups the requester handshake and the memory control pins of
//   mem_bus_master. The bidirectional data bus is not in here: it stays a
//   plain inout port on the block so the tristate net resolves in the parent.
//   master modport : the mem_bus_master block itself
//   slave  modport : the requester / memory side
//   Signals:
//     req_valid/req_ready/req_write/req_addr/req_len : burst request
//     wdata_valid/wdata_ready/wdata                  : write beats
//     resp_valid/resp_data                           : read beats (no backpressure)
//     done                                           : end-of-burst pulse
//     mem_addr/mem_wr/mem_rd                         : registered memory controls
interface mem_bus_master_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AWIDTH-1:0] req_addr;
    logic [LWIDTH-1:0] req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DWIDTH-1:0] wdata;
    logic              resp_valid;
    logic [DWIDTH-1:0] resp_data;
    logic              done;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_rd;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
        output req_ready, wdata_ready, resp_valid, resp_data, done,
               mem_addr, mem_wr, mem_rd
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
        input  req_ready, wdata_ready, resp_valid, resp_data, done,
               mem_addr, mem_wr, mem_rd
    );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Burst initiator for the single-port VeriRISC memory bus. Takes a read or
//   write burst over a valid/ready handshake and sequences mem_addr/mem_wr/
//   mem_rd/mem_data cycle by cycle. Reads are pipelined against the memory's
//   one-cycle registered read; a DONE cycle between bursts gives turnaround.
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : mem_bus_master_if.master (handshakes + memory controls)
//     mem_data : bidirectional memory data, driven only while mem_wr=1
module mem_bus_master #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_master_if.master  bus,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WR_FLUSH, S_READ, S_RD_DRAIN, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;   // next write address
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;             // beats remaining after this one
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rd_prev_q, rd_prev_d;     // mem_rd one cycle ago
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0] resp_data_q, resp_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            rd_prev_q    <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            mem_addr_q   <= mem_addr_d;
            cnt_q        <= cnt_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            rd_prev_q    <= rd_prev_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        mem_wr_d   = 1'b0;
        mem_rd_d   = 1'b0;
        wdata_d    = wdata_q;
        rd_prev_d  = mem_rd_q;
        // The memory presents mem[addr] one cycle after the read was issued,
        // so the bus carries valid data only on the second and later cycles
        // of an unbroken mem_rd run.
        resp_valid_d = mem_rd_q & rd_prev_q;
        resp_data_d  = resp_valid_d ? mem_data : resp_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cnt_d      = bus.req_len;
                    cur_addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d    = S_READ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.req_addr;
                    end
                end
            end
            S_WRITE: begin
                // Stall cycles leave mem_wr low and mem_addr where it was.
                if (bus.wdata_valid) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cur_addr_q;
                    wdata_d    = bus.wdata;
                    cur_addr_d = cur_addr_q + AWIDTH'(1);
                    cnt_d      = cnt_q - LWIDTH'(1);
                    if (cnt_q == '0) state_d = S_WR_FLUSH;
                end
            end
            S_WR_FLUSH: state_d = S_DONE;   // last write is on the bus now
            S_READ: begin
                mem_rd_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_RD_DRAIN;
                end else begin
                    mem_addr_d = mem_addr_q + AWIDTH'(1);
                    cnt_d      = cnt_q - LWIDTH'(1);
                end
            end
            // One extra read of the last address keeps mem_rd high for the
            // cycle in which the final beat is captured.
            S_RD_DRAIN: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.wdata_ready = (state_q == S_WRITE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;

    // Driven strictly from the registered strobe, so reset releases the bus
    // immediately and it can never overlap a read (mem_rd_q and mem_wr_q are
    // never set in the same state).
    assign mem_data = mem_wr_q ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master
//   Drives random and directed read/write bursts into mem_bus_master against
//   a behavioural memory. A transaction-level model schedules, per cycle
//   number, the expected pin activity and read responses; one compare process
//   checks every cycle. Literal expectations pin the model on directed cases.
module tb_mem_bus_master;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int LW = 3;
    localparam int MSZ = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_bus_master_if #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) bus ();
    wire [DW-1:0] mem_data;

    mem_bus_master #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mem_data(mem_data)
    );

    // ---------------- behavioural memory ----------------
    logic [DW-1:0] init_img [MSZ];
    logic [DW-1:0] mem [MSZ];
    logic [DW-1:0] mem_out;
    bit            mem_loaded = 1'b0;
    assign mem_data = bus.mem_rd ? mem_out : {DW{1'bz}};
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= init_img[i];
            mem_loaded <= 1'b1;
        end else begin
            if (bus.mem_rd) mem_out <= mem[bus.mem_addr];
            if (bus.mem_wr) mem[bus.mem_addr] <= mem_data;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(bus.mem_wr && bus.mem_rd));

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    endtask

    // Model: expected activity keyed by cycle number.
    logic [DW-1:0] shadow [MSZ];
    bit            e_rd [int];
    bit            e_wr [int];
    bit            e_busy [int];
    bit            e_wrdy [int];
    bit            e_done [int];
    logic [AW-1:0] e_addr [int];
    logic [DW-1:0] e_bus [int];
    logic [DW-1:0] e_resp [int];
    logic [AW-1:0] m_addr = '0;   // mem_addr holds until the model changes it
    int            free_at = 0;   // first cycle the DUT is idle again

    task automatic model_reset();
        e_rd.delete(); e_wr.delete(); e_busy.delete(); e_wrdy.delete();
        e_done.delete(); e_addr.delete(); e_bus.delete(); e_resp.delete();
        m_addr = '0;
        free_at = 0;
    endtask

    function automatic bit bus_released();
        // An undriven net reads as Z (4-state) or 0 (2-state simulators).
        return $isunknown(mem_data) || (mem_data == '0);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (e_addr.exists(cyc)) m_addr = e_addr[cyc];
            chk("req_ready",   bus.req_ready,   !e_busy.exists(cyc));
            chk("wdata_ready", bus.wdata_ready, e_wrdy.exists(cyc));
            chk("done",        bus.done,        e_done.exists(cyc));
            chk("mem_rd",      bus.mem_rd,      e_rd.exists(cyc));
            chk("mem_wr",      bus.mem_wr,      e_wr.exists(cyc));
            chk("mem_addr",    bus.mem_addr,    m_addr);
            chk("resp_valid",  bus.resp_valid,  e_resp.exists(cyc));
            if (e_resp.exists(cyc)) chk("resp_data", bus.resp_data, e_resp[cyc]);
            if (e_wr.exists(cyc)) chk("bus_wdata", mem_data, e_bus[cyc]);
            else if (!e_rd.exists(cyc)) chk("bus_released", bus_released(), 1);
        end
    end

    // Raw observations used by the literal (hand-computed) checks.
    int wa_q[$];
    int rs_q[$];
    int dn_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr) wa_q.push_back(int'(bus.mem_addr));
            if (bus.resp_valid) rs_q.push_back(int'(bus.resp_data));
            if (bus.done) dn_q.push_back(cyc);
        end
    end

    task automatic clr_obs();
        wa_q.delete(); rs_q.delete(); dn_q.delete();
    endtask

    task automatic chk_q(input string nm, input int got[$], input int want[$]);
        chk({nm, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(nm, got[i], want[i]);
    endtask

    task automatic rst_checks();
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_wdata_ready", bus.wdata_ready, 0);
        chk("rst_bus_released", bus_released(), 1);
    endtask

    // ---------------- drivers ----------------
    logic [DW-1:0] wq[$];
    bit            stall_seq[$];
    int            stall_pct = 0;

    task automatic wait_free();
        int g = 0;
        while (cyc < free_at && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (cyc < free_at) chk("accept_timeout", cyc, free_at);
    endtask

    task automatic wait_idle();
        wait_free();
        @(posedge clk); #1;
    endtask

    task automatic scramble_req(input bit hold);
        bus.req_valid = hold;
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_len   = LW'($urandom);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int n, input bit hold, output int c0);
        logic [AW-1:0] ra;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr = a; bus.req_len = LW'(n - 1);
        wait_free();
        c0 = cyc;
        for (int k = 1; k <= n; k++) begin
            ra = a + AW'(k - 1);
            e_rd[c0 + k] = 1'b1;
            e_addr[c0 + k] = ra;
            e_resp[c0 + k + 2] = shadow[ra];
        end
        e_rd[c0 + n + 1] = 1'b1;
        for (int k = 1; k <= n + 2; k++) e_busy[c0 + k] = 1'b1;
        e_done[c0 + n + 2] = 1'b1;
        free_at = c0 + n + 3;
        @(posedge clk); #1;
        scramble_req(hold);   // must be ignored while busy
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input bit hold, output int c0);
        logic [AW-1:0] wa;
        logic [DW-1:0] d;
        bit            stall;
        int            i = 0;
        int            nst = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = a; bus.req_len = LW'(n - 1);
        wait_free();
        c0 = cyc;
        @(posedge clk); #1;
        scramble_req(hold);
        wa = a;
        while (i < n) begin
            e_busy[cyc] = 1'b1;
            e_wrdy[cyc] = 1'b1;
            if (stall_seq.size() > 0) stall = stall_seq.pop_front();
            else stall = ($urandom_range(0, 99) < stall_pct) && (nst < 16);
            if (stall) begin
                nst++;
                bus.wdata_valid = 1'b0;
                bus.wdata = DW'($urandom);
            end else begin
                d = wq[i];
                bus.wdata_valid = 1'b1;
                bus.wdata = d;
                e_wr[cyc + 1] = 1'b1;
                e_addr[cyc + 1] = wa;
                e_bus[cyc + 1] = d;
                shadow[wa] = d;
                wa = wa + AW'(1);
                i++;
            end
            @(posedge clk); #1;
        end
        bus.wdata_valid = 1'b0;
        e_busy[cyc] = 1'b1;
        e_busy[cyc + 1] = 1'b1;
        e_done[cyc + 1] = 1'b1;
        free_at = cyc + 2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int c1;
        int want[$];
        int nb;
        logic [AW-1:0] a;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0;
        for (int i = 0; i < MSZ; i++) begin
            init_img[i] = DW'($urandom);
            shadow[i] = init_img[i];
        end

        // Reset asserted mid-cycle, before any clock edge.
        #2 rst_n = 1'b0;
        #1 rst_checks();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 4 @5, read back.
        clr_obs();
        wq = {8'h11, 8'h22, 8'h33, 8'h44};
        do_write(5, 4, 1'b0, c0);
        wait_idle();
        want = {5, 6, 7, 8};
        chk_q("wr_addrs", wa_q, want);
        chk("wr_done_lat", (dn_q.size() > 0) ? dn_q[0] - c0 : -1, 6);
        clr_obs();
        do_read(5, 4, 1'b0, c0);
        bus.req_valid = 1'b0;
        wait_idle();
        want = {'h11, 'h22, 'h33, 'h44};
        chk_q("rd_data", rs_q, want);
        chk("rd_done_lat", (dn_q.size() > 0) ? dn_q[0] - c0 : -1, 6);

        // Address wrap.
        clr_obs();
        wq = {8'hA1, 8'hB2, 8'hC3};
        do_write(30, 3, 1'b0, c0);
        wait_idle();
        want = {30, 31, 0};
        chk_q("wrap_addrs", wa_q, want);
        clr_obs();
        do_read(30, 3, 1'b0, c0);
        bus.req_valid = 1'b0;
        wait_idle();
        want = {'hA1, 'hB2, 'hC3};
        chk_q("wrap_data", rs_q, want);

        // Two stall cycles after beat 1.
        clr_obs();
        wq = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
        stall_seq = {1'b0, 1'b1, 1'b1};
        do_write(12, 4, 1'b0, c0);
        wait_idle();
        want = {12, 13, 14, 15};
        chk_q("stall_addrs", wa_q, want);
        chk("stall_done_lat", (dn_q.size() > 0) ? dn_q[0] - c0 : -1, 8);
        do_read(12, 4, 1'b0, c0);
        bus.req_valid = 1'b0;
        wait_idle();

        // Single-beat read with req_valid held; next request waits for IDLE.
        clr_obs();
        do_read(20, 1, 1'b1, c0);
        wq = {8'h01, 8'h02};
        do_write(21, 2, 1'b0, c1);
        wait_idle();
        chk("single_resp_count", rs_q.size(), 1);
        chk("next_accept_gap", c1 - c0, 4);

        // Reset during beat 2 of an 8-beat read.
        do_read(3, 8, 1'b0, c0);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 rst_checks();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        clr_obs();
        repeat (3) @(posedge clk);
        #1 chk("post_rst_resp", rs_q.size(), 0);
        do_read(9, 2, 1'b0, c0);
        bus.req_valid = 1'b0;
        wait_idle();

        // Random back-to-back traffic.
        for (int t = 0; t < 40; t++) begin
            a = AW'($urandom);
            nb = $urandom_range(1, 1 << LW);
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int i = 0; i < nb; i++) wq.push_back(DW'($urandom));
                stall_pct = $urandom_range(0, 50);
                do_write(a, nb, 1'($urandom), c0);
            end else begin
                do_read(a, nb, 1'($urandom), c0);
            end
        end
        bus.req_valid = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < MSZ; i++) chk("mem_final", mem[i], shadow[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
